// File: rtl/ringnode_ff_if.sv
// ----------------------------------------------------------------------------
// ringnode_ff_if
// Client-side bundle of one spinet ring node. The node (slave modport) takes
// packets to send from the client and hands it received ring words. The
// client (master modport) sits on the other side.
//   tx_valid/tx_ready/tx_data : client -> TX FIFO, valid/ready handshake
//   rx_valid/rx_ready/rx_data : RX FIFO head -> client, valid/ready handshake
//   busy                      : one of our packets is on the ring, not yet acked
//   tx_level/rx_level         : FIFO occupancies (depth when full)
// ----------------------------------------------------------------------------
interface ringnode_ff_if #(
    parameter int WIDTH   = 16,
    parameter int TXDEPTH = 4,
    parameter int RXDEPTH = 16
);
    logic                       tx_valid;
    logic                       tx_ready;
    logic [WIDTH-1:0]           tx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic [WIDTH-1:0]           rx_data;
    logic                       busy;
    logic [$clog2(TXDEPTH):0]   tx_level;
    logic [$clog2(RXDEPTH):0]   rx_level;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, busy, tx_level, rx_level
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, busy, tx_level, rx_level
    );
endinterface

// File: rtl/ringnode_ff.sv
// ----------------------------------------------------------------------------
// ringnode_ff
// One node of the spinet slotted ring. Words arrive on fromring and leave one
// cycle later on toring. Word layout (MSB first):
//   FULL | ACK | DST[ABITS] | SRC[ABITS] | payload
// The node seizes free slots for the head of its TX FIFO (one packet in
// flight at a time), accepts payloads addressed to it into its RX FIFO and
// turns them into acks, and frees the slot when its own ack comes back. The
// TX head is popped only on ack, so packet order is preserved.
//
// Ports:
//   clk      : sole clock
//   rst      : synchronous active-high reset
//   fromring : slot word from the upstream node
//   toring   : registered slot word to the downstream node
//   cli      : client bundle (ringnode_ff_if.slave)
//
// Build option RINGNODE_BCAST_EN: when defined, DST all-ones is a broadcast.
// Every other node copies it (if its RX has room) and passes it on; the
// source removes it when it comes back. Broadcasts are never acked. When not
// defined, all-ones is an ordinary unicast address.
// ----------------------------------------------------------------------------
module ringnode_ff #(
    parameter int WIDTH   = 16,
    parameter int ABITS   = 3,
    parameter int ADDRESS = 0,
    parameter int TXDEPTH = 4,
    parameter int RXDEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fromring,
    output logic [WIDTH-1:0] toring,
    ringnode_ff_if.slave     cli
);
    localparam int TPW    = $clog2(TXDEPTH);
    localparam int RPW    = $clog2(RXDEPTH);
    localparam int FULL_B = WIDTH - 1;
    localparam int ACK_B  = WIDTH - 2;
    localparam int DST_HI = WIDTH - 3;
    localparam int SRC_HI = WIDTH - 3 - ABITS;

    localparam logic [ABITS-1:0] MY_ADDR  = ABITS'(ADDRESS);
`ifdef RINGNODE_BCAST_EN
    localparam logic [ABITS-1:0] ALL_ONES = {ABITS{1'b1}};
`endif
    localparam logic [TPW-1:0] TXP_ONE = TPW'(1);
    localparam logic [TPW:0]   TXL_ONE = (TPW+1)'(1);
    localparam logic [RPW-1:0] RXP_ONE = RPW'(1);
    localparam logic [RPW:0]   RXL_ONE = (RPW+1)'(1);

    // Field helpers
    function automatic logic [ABITS-1:0] f_dst(input logic [WIDTH-1:0] w);
        return w[DST_HI -: ABITS];
    endfunction

    function automatic logic [ABITS-1:0] f_src(input logic [WIDTH-1:0] w);
        return w[SRC_HI -: ABITS];
    endfunction

    // Word put on the ring when seizing: client DST/payload, our SRC, FULL=1
    function automatic logic [WIDTH-1:0] f_seize(input logic [WIDTH-1:0] head);
        logic [WIDTH-1:0] w;
        w                 = head;
        w[FULL_B]         = 1'b1;
        w[ACK_B]          = 1'b0;
        w[SRC_HI -: ABITS] = MY_ADDR;
        return w;
    endfunction

    // Storage and state
    logic [WIDTH-1:0] r_tx_mem [TXDEPTH];
    logic [TPW-1:0]   r_tx_wp;
    logic [TPW-1:0]   r_tx_rp;
    logic [TPW:0]     r_tx_level;
    logic [WIDTH-1:0] r_rx_mem [RXDEPTH];
    logic [RPW-1:0]   r_rx_wp;
    logic [RPW-1:0]   r_rx_rp;
    logic [RPW:0]     r_rx_level;
    logic             r_busy;
    logic [WIDTH-1:0] r_toring;

    // Combinational control
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_seize;
    logic             w_release;
    logic [WIDTH-1:0] w_tx_head;
    logic [WIDTH-1:0] w_outpkt;

    assign w_tx_full  = (r_tx_level == TXDEPTH[TPW:0]);
    assign w_tx_empty = (r_tx_level == '0);
    assign w_rx_full  = (r_rx_level == RXDEPTH[RPW:0]);
    assign w_rx_empty = (r_rx_level == '0);
    assign w_tx_head  = r_tx_mem[r_tx_rp];

    assign w_tx_push  = cli.tx_valid & ~w_tx_full;
    assign w_rx_pop   = cli.rx_ready & ~w_rx_empty;
    // A stale ack must never underflow the TX FIFO
    assign w_tx_pop   = w_release & ~w_tx_empty;

    // Slot decode: at most one action per cycle, default is pass-through
    always_comb begin
        w_outpkt  = fromring;
        w_seize   = 1'b0;
        w_release = 1'b0;
        w_rx_push = 1'b0;
        case (fromring[FULL_B:ACK_B])
            2'b00: begin
                if (!w_tx_empty && !r_busy) begin
                    w_seize  = 1'b1;
                    w_outpkt = f_seize(w_tx_head);
                end else begin
                    w_outpkt = fromring;
                end
            end
            2'b10, 2'b11: begin
`ifdef RINGNODE_BCAST_EN
                if (f_dst(fromring) == ALL_ONES) begin
                    if (f_src(fromring) == MY_ADDR) begin
                        // broadcast back at its source: remove it
                        w_outpkt  = '0;
                        w_release = 1'b1;
                    end else if (!w_rx_full) begin
                        w_rx_push = 1'b1;
                        w_outpkt  = fromring;
                    end else begin
                        w_outpkt  = fromring;
                    end
                end else if (f_dst(fromring) == MY_ADDR) begin
                    if (!w_rx_full) begin
                        w_rx_push              = 1'b1;
                        w_outpkt[FULL_B:ACK_B] = 2'b01;
                    end else begin
                        w_outpkt = fromring;
                    end
                end else begin
                    w_outpkt = fromring;
                end
`else
                if (f_dst(fromring) == MY_ADDR) begin
                    if (!w_rx_full) begin
                        w_rx_push              = 1'b1;
                        w_outpkt[FULL_B:ACK_B] = 2'b01;
                    end else begin
                        // RX full: leave it on the ring to retry next lap
                        w_outpkt = fromring;
                    end
                end else begin
                    w_outpkt = fromring;
                end
`endif
            end
            2'b01: begin
                if (f_src(fromring) == MY_ADDR) begin
                    w_outpkt  = '0;
                    w_release = 1'b1;
                end else begin
                    w_outpkt = fromring;
                end
            end
            default: begin
                w_outpkt = fromring;
            end
        endcase
    end

    // Ring output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toring <= '0;
        end else begin
            r_toring <= w_outpkt;
        end
    end

    // In-flight flag: set on seize, cleared when our packet is retired
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (w_seize) begin
            r_busy <= 1'b1;
        end else if (w_release) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= r_busy;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= cli.tx_data;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wp <= r_tx_wp + TXP_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + TXP_ONE;
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + TXL_ONE;
                2'b01:   r_tx_level <= r_tx_level - TXL_ONE;
                default: r_tx_level <= r_tx_level;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wp] <= fromring;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wp <= r_rx_wp + RXP_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + RXP_ONE;
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + RXL_ONE;
                2'b01:   r_rx_level <= r_rx_level - RXL_ONE;
                default: r_rx_level <= r_rx_level;
            endcase
        end
    end

    // Outputs are decoded straight from registered state
    assign toring       = r_toring;
    assign cli.tx_ready = ~w_tx_full;
    assign cli.rx_valid = ~w_rx_empty;
    assign cli.rx_data  = r_rx_mem[r_rx_rp];
    assign cli.busy     = r_busy;
    assign cli.tx_level = r_tx_level;
    assign cli.rx_level = r_rx_level;

endmodule
